// File: rtl/rom_loader.sv
// rom_loader: packs 16-bit HPS download halfwords into 32-bit little-endian
// SDRAM writes issued over a toggle req/ack handshake. It stalls the HPS
// while a write is outstanding, flushes a trailing odd halfword, bounds the
// load to SIZE_MAX bytes and reports BUSY/DONE/OVF to the core.
module rom_loader #(
    parameter logic [5:0]  INDEX_MAX = 6'h01,
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter logic [24:0] SIZE_MAX  = 25'h200000
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        IOCTL_DOWNLOAD,
    input  logic [7:0]  IOCTL_INDEX,
    input  logic        IOCTL_WR,
    input  logic [15:0] IOCTL_DOUT,
    output logic        IOCTL_WAIT,
    output logic [24:0] SDRAM_WADDR,
    output logic [31:0] SDRAM_DIN,
    output logic [3:0]  SDRAM_BE,
    output logic        SDRAM_WE_REQ,
    input  logic        SDRAM_WE_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVF
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_FLUSH,
        S_FWAIT,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic        act_q, act_d;
    logic        wait_q, wait_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        req_q, req_d;
    logic [24:0] waddr_q, waddr_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  be_q, be_d;
    // One bit wider than the address so counter+4 never wraps before the compare.
    logic [25:0] cnt_q, cnt_d;

    logic        active;
    logic        ack_match;
    logic        fits_word;
    logic        fits_half;
    logic        unused_idx_hi;

    // Only the low six index bits select the download slot.
    assign active        = IOCTL_DOWNLOAD & (IOCTL_INDEX[5:0] <= INDEX_MAX);
    assign unused_idx_hi = ^IOCTL_INDEX[7:6];
    assign ack_match     = (SDRAM_WE_ACK == req_q);
    assign fits_word     = (cnt_q + 26'd4) <= {1'b0, SIZE_MAX};
    assign fits_half     = (cnt_q + 26'd2) <= {1'b0, SIZE_MAX};

    // Next-state and datapath updates for the load sequencer.
    always_comb begin
        state_d = state_q;
        act_d   = active;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        req_d   = req_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        be_d    = be_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Start only on a fresh rising edge of an accepted download.
                if (active && !act_q) begin
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    cnt_d   = 26'd0;
                    waddr_d = BASE_ADDR;
                    din_d   = 32'd0;
                    be_d    = 4'h0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                // Download ending takes priority over a coincident strobe.
                if (!active) begin
                    state_d = S_FIN;
                end else if (IOCTL_WR) begin
                    din_d[15:0] = IOCTL_DOUT;
                    state_d     = S_HI;
                end
            end
            S_HI: begin
                if (!active) begin
                    state_d = S_FLUSH;
                end else if (IOCTL_WR) begin
                    din_d[31:16] = IOCTL_DOUT;
                    be_d         = 4'hF;
                    if (fits_word) begin
                        req_d   = ~req_q;
                        wait_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        // Beyond the size bound: drop the word, keep draining.
                        ovf_d   = 1'b1;
                        state_d = S_LO;
                    end
                end
            end
            S_WAIT: begin
                // Fields stay frozen until the controller echoes the toggle.
                if (ack_match) begin
                    wait_d  = 1'b0;
                    waddr_d = waddr_q + 25'd4;
                    cnt_d   = cnt_q + 26'd4;
                    state_d = active ? S_LO : S_FIN;
                end
            end
            S_FLUSH: begin
                // Odd trailing halfword goes out as a 2-byte write.
                be_d         = 4'h3;
                din_d[31:16] = 16'd0;
                if (fits_half) begin
                    req_d   = ~req_q;
                    state_d = S_FWAIT;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FWAIT: begin
                if (ack_match) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset re-aligns REQ to ACK so no write fires.
    always_ff @(posedge CLK) begin
        if (!RESn) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            wait_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            req_q   <= SDRAM_WE_ACK;
            waddr_q <= BASE_ADDR;
            din_q   <= 32'd0;
            be_q    <= 4'h0;
            cnt_q   <= 26'd0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            req_q   <= req_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IOCTL_WAIT   = wait_q;
    assign SDRAM_WADDR  = waddr_q;
    assign SDRAM_DIN    = din_q;
    assign SDRAM_BE     = be_q;
    assign SDRAM_WE_REQ = req_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign OVF          = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: a main instance (2 MiB bound) checked against a write
// scoreboard, plus a SIZE_MAX=8 instance on the same download bus for overflow.
module tb_rom_loader;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        IOCTL_DOWNLOAD;
    logic [7:0]  IOCTL_INDEX;
    logic        IOCTL_WR;
    logic [15:0] IOCTL_DOUT;
    logic        ack = 1'b0;
    logic        ack2 = 1'b0;
    logic        ack_hold = 1'b0;
    int          ack_dly = 3;

    logic        wait1, req, busy, done, ovf;
    logic [24:0] waddr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        wait2, req2, busy2, done2, ovf2;
    logic [24:0] waddr2;
    logic [31:0] din2;
    logic [3:0]  be2;

    always #5 CLK = ~CLK;

    rom_loader u_dut (
        .CLK(CLK), .RESn(RESn), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
        .IOCTL_WR(IOCTL_WR), .IOCTL_DOUT(IOCTL_DOUT), .IOCTL_WAIT(wait1),
        .SDRAM_WADDR(waddr), .SDRAM_DIN(din), .SDRAM_BE(be), .SDRAM_WE_REQ(req),
        .SDRAM_WE_ACK(ack), .BUSY(busy), .DONE(done), .OVF(ovf)
    );

    rom_loader #(.INDEX_MAX(6'h01), .BASE_ADDR(25'h0), .SIZE_MAX(25'd8)) u_ovf (
        .CLK(CLK), .RESn(RESn), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
        .IOCTL_WR(IOCTL_WR), .IOCTL_DOUT(IOCTL_DOUT), .IOCTL_WAIT(wait2),
        .SDRAM_WADDR(waddr2), .SDRAM_DIN(din2), .SDRAM_BE(be2), .SDRAM_WE_REQ(req2),
        .SDRAM_WE_ACK(ack2), .BUSY(busy2), .DONE(done2), .OVF(ovf2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [24:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];

    function automatic wr_t mk(input logic [24:0] a, input logic [31:0] d, input logic [3:0] b);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be   = b;
        return w;
    endfunction

    int   wait_cnt = 0, busy_cnt = 0, done_cnt = 0, req_tog = 0, req2_tog = 0;
    logic req_prev = 1'b0, req2_prev = 1'b0, pending = 1'b0, unstable = 1'b0;
    wr_t  cur;

    // Monitor: pops the scoreboard on each REQ toggle, checks field stability.
    initial forever begin
        @(negedge CLK);
        if (!RESn) begin
            req_prev  = req;
            req2_prev = req2;
            pending   = 1'b0;
        end else begin
            if (wait1) wait_cnt++;
            if (busy)  busy_cnt++;
            if (done)  done_cnt++;
            if (req2 != req2_prev) begin
                req2_prev = req2;
                req2_tog++;
            end
            if (req != req_prev) begin
                req_prev = req;
                req_tog++;
                cur      = mk(waddr, din, be);
                pending  = 1'b1;
                unstable = 1'b0;
                if (exp_q.size() == 0) chk("write_unexpected", 64'(exp_q.size()), 64'd1);
                else                   chk("write", 64'(cur), 64'(exp_q.pop_front()));
            end else if (pending) begin
                if (req == ack) begin
                    chk("fields_stable", 64'(unstable), 64'd0);
                    pending = 1'b0;
                end else if (mk(waddr, din, be) != cur) begin
                    unstable = 1'b1;
                end
            end
        end
    end

    // Main controller model: echoes REQ after ack_dly cycles unless held off.
    initial forever begin
        @(negedge CLK);
        if (RESn && !ack_hold && req != ack) begin
            repeat (ack_dly) @(negedge CLK);
            ack = req;
        end
    end

    // Overflow instance controller: echoes REQ one cycle later.
    initial forever begin
        @(negedge CLK);
        if (RESn && req2 != ack2) ack2 = req2;
    end

    task automatic send_hw(input logic [15:0] d);
        int t = 0;
        while ((wait1 || wait2) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 500) chk("wait_release_timeout", 64'(t), 64'd0);
        IOCTL_DOUT = d;
        IOCTL_WR   = 1'b1;
        @(negedge CLK);
        IOCTL_WR   = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] idx);
        IOCTL_INDEX    = idx;
        IOCTL_DOWNLOAD = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge CLK);
        while ((busy || busy2) && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 1000) chk("idle_timeout", 64'(t), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end

    int w0, d0, b0, t0, r0;

    initial begin
        RESn = 1'b0; IOCTL_DOWNLOAD = 1'b0; IOCTL_INDEX = 8'h00; IOCTL_WR = 1'b0; IOCTL_DOUT = 16'h0;
        repeat (3) @(negedge CLK);
        chk("rst_wait",  64'(wait1), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_ovf",   64'(ovf),   64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_din",   64'(din),   64'd0);
        chk("rst_be",    64'(be),    64'd0);
        chk("rst_req",   64'(req),   64'(ack));
        RESn = 1'b1;
        @(negedge CLK);

        // Four halfwords -> two full words.
        w0 = wait_cnt; d0 = done_cnt;
        exp_q.push_back(mk(25'd0, 32'h2222_1111, 4'hF));
        exp_q.push_back(mk(25'd4, 32'h4444_3333, 4'hF));
        start_load(8'h00);
        send_hw(16'h1111); send_hw(16'h2222); send_hw(16'h3333); send_hw(16'h4444);
        IOCTL_DOWNLOAD = 1'b0;
        wait_idle();
        chk("t1_wait_cycles", 64'(wait_cnt - w0), 64'd8);
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_after",  64'(busy), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t1_ovf8_exact",  64'(ovf2), 64'd0);

        // Three halfwords -> odd tail flushed with BE=3.
        w0 = wait_cnt; d0 = done_cnt;
        exp_q.push_back(mk(25'd0, 32'hBBBB_AAAA, 4'hF));
        exp_q.push_back(mk(25'd4, 32'h0000_CCCC, 4'h3));
        start_load(8'h01);
        send_hw(16'hAAAA); send_hw(16'hBBBB); send_hw(16'hCCCC);
        IOCTL_DOWNLOAD = 1'b0;
        wait_idle();
        chk("t2_wait_cycles", 64'(wait_cnt - w0), 64'd4);
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_ovf8",        64'(ovf2), 64'd0);

        // Six halfwords: the 8-byte instance overflows on the third word.
        d0 = done_cnt; t0 = req2_tog;
        exp_q.push_back(mk(25'd0, 32'h0202_0101, 4'hF));
        exp_q.push_back(mk(25'd4, 32'h0404_0303, 4'hF));
        exp_q.push_back(mk(25'd8, 32'h0606_0505, 4'hF));
        start_load(8'h00);
        send_hw(16'h0101); send_hw(16'h0202); send_hw(16'h0303);
        send_hw(16'h0404); send_hw(16'h0505); send_hw(16'h0606);
        IOCTL_DOWNLOAD = 1'b0;
        wait_idle();
        chk("t3_ovf8_writes", 64'(req2_tog - t0), 64'd2);
        chk("t3_ovf8_flag",   64'(ovf2), 64'd1);
        chk("t3_main_ovf",    64'(ovf),  64'd0);
        chk("t3_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Index 2 is not a ROM slot: nothing must move.
        w0 = wait_cnt; d0 = done_cnt; b0 = busy_cnt; t0 = req2_tog; r0 = req_tog;
        start_load(8'h02);
        send_hw(16'hDEAD); send_hw(16'hBEEF); send_hw(16'hCAFE); send_hw(16'hF00D);
        IOCTL_DOWNLOAD = 1'b0;
        repeat (3) @(negedge CLK);
        IOCTL_INDEX = 8'h00;
        chk("t4_req_toggles",  64'(req_tog - r0),  64'd0);
        chk("t4_req2_toggles", 64'(req2_tog - t0), 64'd0);
        chk("t4_wait_cycles",  64'(wait_cnt - w0), 64'd0);
        chk("t4_busy_cycles",  64'(busy_cnt - b0), 64'd0);
        chk("t4_done_pulses",  64'(done_cnt - d0), 64'd0);
        chk("t4_ovf8_kept",    64'(ovf2), 64'd1);

        // Reset while a write is outstanding, then a clean reload.
        ack_hold = 1'b1;
        exp_q.push_back(mk(25'd0, 32'h8888_7777, 4'hF));
        start_load(8'h00);
        send_hw(16'h7777); send_hw(16'h8888);
        repeat (5) @(negedge CLK);
        chk("t5_wait_held", 64'(wait1), 64'd1);
        RESn = 1'b0; IOCTL_DOWNLOAD = 1'b0;
        @(negedge CLK);
        chk("t5_rst_wait", 64'(wait1), 64'd0);
        chk("t5_rst_busy", 64'(busy),  64'd0);
        chk("t5_rst_req",  64'(req),   64'(ack));
        RESn = 1'b1; ack_hold = 1'b0;
        @(negedge CLK);
        exp_q.push_back(mk(25'd0, 32'h6666_5555, 4'hF));
        start_load(8'h00);
        send_hw(16'h5555); send_hw(16'h6666);
        IOCTL_DOWNLOAD = 1'b0;
        wait_idle();
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t5_waddr_next",  64'(waddr), 64'd4);

        // Slow controller: 50-cycle ACK delay.
        ack_dly = 50;
        w0 = wait_cnt;
        exp_q.push_back(mk(25'd0, 32'h5678_1234, 4'hF));
        exp_q.push_back(mk(25'd4, 32'hDEF0_9ABC, 4'hF));
        start_load(8'h00);
        send_hw(16'h1234); send_hw(16'h5678); send_hw(16'h9ABC);
        chk("t6_lo_packed", 64'(din[15:0]),  64'h9ABC);
        chk("t6_hi_kept",   64'(din[31:16]), 64'h5678);
        send_hw(16'hDEF0);
        IOCTL_DOWNLOAD = 1'b0;
        wait_idle();
        chk("t6_wait_cycles", 64'(wait_cnt - w0), 64'd102);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        ack_dly = 3;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Stand-alone HPS-to-SDRAM ROM/BIOS loader; replaces the inline loader logic ahead of the SDRAM controller write port.
- Packs consecutive 16-bit ioctl download words into 32-bit little-endian SDRAM writes.
- Issues writes over the toggle req/ack handshake and throttles the HPS with IOCTL_WAIT.
- Flushes a trailing odd halfword, bounds the load to a configured size and reports BUSY/DONE/OVF to the core.

Parameters:
- INDEX_MAX, 6'h01, highest IOCTL_INDEX[5:0] accepted as a ROM/BIOS download.
- BASE_ADDR, 25'h0, SDRAM byte address of the first 32-bit word.
- SIZE_MAX, 25'h200000, maximum load size in bytes; must be a multiple of 4.

Ports:
- CLK  in  1  system clock.
- RESn  in  1  synchronous active-low reset. Sampled on CLK rising edge.
- IOCTL_DOWNLOAD  in  1  download active.
- IOCTL_INDEX  in  8  download index.
- IOCTL_WR  in  1  one-cycle strobe; IOCTL_DOUT valid.
- IOCTL_DOUT  in  16  download halfword.
- IOCTL_WAIT  out  1  stall request to HPS.
- SDRAM_WADDR  out  25  write byte address, 4-aligned.
- SDRAM_DIN  out  32  write data.
- SDRAM_BE  out  4  byte enables, active high.
- SDRAM_WE_REQ  out  1  toggle: each edge requests one write.
- SDRAM_WE_ACK  in  1  write completed when equal to SDRAM_WE_REQ.
- BUSY  out  1  a load is in progress.
- DONE  out  1  one-cycle pulse at end of load.
- OVF  out  1  sticky: data arrived beyond SIZE_MAX.

Behaviour:
- Acceptance: active = IOCTL_DOWNLOAD & (IOCTL_INDEX[5:0] <= INDEX_MAX). All other downloads are ignored; outputs do not change.
- Reset (RESn=0): state=IDLE.
  - IOCTL_WAIT=0, BUSY=0, DONE=0, OVF=0.
  - SDRAM_WADDR=BASE_ADDR, SDRAM_DIN=0, SDRAM_BE=0.
  - SDRAM_WE_REQ<=SDRAM_WE_ACK, so no spurious request is issued.
  - Reset mid-write abandons the load; the partial halfword is discarded.
- States:
  - IDLE: on rising edge of active -> LO. Set BUSY=1, OVF=0, byte counter=0, SDRAM_WADDR=BASE_ADDR.
  - LO: on IOCTL_WR, latch DIN[15:0]=IOCTL_DOUT -> HI.
  - HI: on IOCTL_WR, latch DIN[31:16]=IOCTL_DOUT and set BE=4'hF.
    - If counter+4 <= SIZE_MAX: toggle REQ, set IOCTL_WAIT=1 on the same edge -> WAIT.
    - Else: set OVF=1, drop the word -> LO.
  - WAIT: when ACK==REQ, clear IOCTL_WAIT, add 4 to SDRAM_WADDR and the counter.
    - -> LO if still active; otherwise -> FIN.
  - Falling edge of active while in LO or WAIT-complete -> FIN.
  - Falling edge in HI (odd halfword count) -> FLUSH.
  - FLUSH: BE=4'h3, DIN[31:16]=0. If counter+2 <= SIZE_MAX, toggle REQ -> FWAIT; else set OVF -> FIN.
  - FWAIT: when ACK==REQ -> FIN.
  - FIN: DONE=1 for one cycle, BUSY=0 -> IDLE.
- Latency:
  - IOCTL_WAIT is high from the cycle after the 2nd halfword's IOCTL_WR until the cycle after ACK matches.
  - IOCTL_WR strobes during WAIT/FWAIT are a protocol violation; the block ignores them and they need no handling.
- Field stability: SDRAM_WADDR, SDRAM_DIN and SDRAM_BE hold steady from the REQ toggle until the ACK match.
- Byte counter: 26-bit, so the comparison against SIZE_MAX cannot wrap. SDRAM_WADDR wraps modulo 2^25.
- Simultaneous events:
  - Falling edge of active on the same cycle as ACK match: the write completes first, then -> FIN.
  - IOCTL_WR on the same cycle as the active falling edge: the strobe is ignored.

Test Plan:
- Load 4 halfwords 1111,2222,3333,4444 (idx 0), ACK echoed 3 cycles after REQ -> writes 2222_1111@0 and 4444_3333@4, BE=F; WAIT high 4 cycles per write; DONE pulse once; BUSY low after.
- Load 3 halfwords AAAA,BBBB,CCCC then drop download -> 2nd write is 0000_CCCC@4, BE=3; DONE after its ACK.
- SIZE_MAX=8, 6 halfwords -> exactly 2 writes (@0, @4), OVF=1, no REQ toggle for the 3rd word, DONE pulses.
- Index 2 download with 4 strobes -> REQ never toggles, WAIT stays 0, BUSY stays 0, no DONE.
- RESn low while in WAIT (ACK withheld) -> next cycle WAIT=0, BUSY=0, REQ==ACK. New load restarts at BASE_ADDR with no stale data.
- ACK delayed 50 cycles -> WAIT held 50+ cycles; WADDR, DIN and BE stable throughout; the next halfword after release is packed to DIN[15:0].
